// File: rtl/score_pulse_if.sv
// Signal bundle between the prize-chute sensor side and the score counter.
// The slave modport is the score_pulse_sender side.
interface score_pulse_if #(
  parameter int MAX_PENDING = 7,
  parameter int PEND_W      = $clog2(MAX_PENDING + 1)
);
  logic              prize_sensor;
  logic              game_active;
  logic              increment_score;
  logic [PEND_W-1:0] pending;
  logic              overflow;
  logic              busy;

  modport master (
    output prize_sensor,
    output game_active,
    input  increment_score,
    input  pending,
    input  overflow,
    input  busy
  );

  modport slave (
    input  prize_sensor,
    input  game_active,
    output increment_score,
    output pending,
    output overflow,
    output busy
  );
endinterface

// File: rtl/score_pulse_sender.sv
// Turns prize-chute hits into spaced increment_score pulses, queuing up to MAX_PENDING hits.
// Define SENDER_DEBOUNCE_EN to put a DEBOUNCE_CYCLES-long debouncer on the synced sensor.
module score_pulse_sender #(
  parameter int PULSE_CYCLES    = 16,
  parameter int GAP_CYCLES      = 16,
  parameter int MAX_PENDING     = 7,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic         clock,
  input  logic         reset,
  score_pulse_if.slave bus
);

  localparam int PEND_W  = $clog2(MAX_PENDING + 1);
  localparam int PG_MAX  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (PG_MAX > DEBOUNCE_CYCLES) ? PG_MAX : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_FULL  = PEND_W'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PULSE_HIGH = 2'd1,
    GAP        = 2'd2
  } state_t;

  // Input synchronisers
  logic [1:0] sensor_sync;
  logic [1:0] active_sync;
  logic       sensor_s;
  logic       act_s;

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample the pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sensor_sync <= '0;
      active_sync <= '0;
    end else begin
      sensor_sync <= {sensor_sync[0], bus.prize_sensor};
      active_sync <= {active_sync[0], bus.game_active};
    end
  end

  assign sensor_s = sensor_sync[1];
  assign act_s    = active_sync[1];

  // Accepted sensor level: either debounced or a one-cycle registered copy
  logic sensor_level;

`ifdef SENDER_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] deb_cnt;

  // The level flips only after the synced input disagrees with it for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sensor_level <= 1'b0;
      deb_cnt      <= '0;
    end else if (sensor_s == sensor_level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      sensor_level <= sensor_s;
      deb_cnt      <= '0;
    end else begin
      deb_cnt <= deb_cnt + CNT_W'(1);
    end
  end
`else
  always_ff @(posedge clock) begin
    if (!reset) begin
      sensor_level <= 1'b0;
    end else begin
      sensor_level <= sensor_s;
    end
  end
`endif

  // Rising-edge detect on the accepted level
  logic sensor_prev;
  logic hit;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sensor_prev <= 1'b0;
    end else begin
      sensor_prev <= sensor_level;
    end
  end

  assign hit = sensor_level & ~sensor_prev & act_s;

  // Pulse FSM and queue state
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              inc_q, inc_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic              launch;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      inc_q      <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inc_q      <= inc_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: each combinational output is given a default before the case so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc_d   = inc_q;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        inc_d = 1'b0;
        if (act_s && (pending_q != '0)) begin
          launch  = 1'b1;
          state_d = PULSE_HIGH;
          inc_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      PULSE_HIGH: begin
        // Losing game_active cuts the pulse short but still enforces a full gap
        if (!act_s || (cnt_q == PULSE_LAST)) begin
          state_d = GAP;
          inc_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        inc_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        inc_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // A hit coinciding with a launch replaces the launched entry, so it can
  // never overflow even when the queue is full.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (!act_s) begin
      pending_d = '0;
    end else if (hit && !launch) begin
      if (pending_q == PEND_FULL) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + PEND_W'(1);
      end
    end else if (launch && !hit) begin
      pending_d = pending_q - PEND_W'(1);
    end
  end

  assign bus.increment_score = inc_q;
  assign bus.pending         = pending_q;
  assign bus.overflow        = overflow_q;
  assign bus.busy            = (state_q != IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_score_pulse_sender.sv
// Directed bench for score_pulse_sender: a table-driven single-hit vector set plus
// hand-written sequences for queueing, overflow, game_active loss and launch collisions.
module tb_score_pulse_sender;

  localparam int P  = 4;
  localparam int G  = 4;
  localparam int MP = 3;
  localparam int D  = 8;
  localparam int NS = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;

  score_pulse_if #(.MAX_PENDING(MP)) bus ();

  score_pulse_sender #(
    .PULSE_CYCLES   (P),
    .GAP_CYCLES     (G),
    .MAX_PENDING    (MP),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic sensor;
    int   inc;
    int   pend;
    int   ovf;
    int   busy;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-sequence stimulus and sampled history; index n = after the n-th edge
  logic sens_v [0:NS-1];
  logic act_v  [0:NS-1];
  int   inc_h  [0:NS-1];
  int   pend_h [0:NS-1];
  int   ovf_h  [0:NS-1];
  int   busy_h [0:NS-1];
  int   rises  [0:7];
  int   n_rises;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic record(input int n);
    inc_h[n]  = int'(bus.increment_score);
    pend_h[n] = int'(bus.pending);
    ovf_h[n]  = int'(bus.overflow);
    busy_h[n] = int'(bus.busy);
  endtask

  task automatic clear_stim();
    for (int n = 0; n < NS; n++) begin
      sens_v[n] = 1'b0;
      act_v[n]  = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset            = 1'b0;
    bus.prize_sensor = 1'b0;
    bus.game_active  = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    repeat (4) tick();
  endtask

  task automatic run(input int ncyc);
    record(0);
    for (int n = 1; n <= ncyc; n++) begin
      bus.prize_sensor = sens_v[n];
      bus.game_active  = act_v[n];
      tick();
      record(n);
    end
  endtask

  task automatic find_rises(input int last);
    n_rises = 0;
    for (int i = 0; i < 8; i++) rises[i] = -1;
    for (int n = 1; n <= last; n++) begin
      if (inc_h[n] == 1 && inc_h[n-1] == 0) begin
        if (n_rises < 8) rises[n_rises] = n;
        n_rises++;
      end
    end
  endtask

  task automatic max_pend(input int first, input int last, output int m);
    m = 0;
    for (int n = first; n <= last; n++) if (pend_h[n] > m) m = pend_h[n];
  endtask

  vec_t tbl [0:13];
  int   m;

  initial begin
    bus.prize_sensor = 1'b0;
    bus.game_active  = 1'b1;

    // Reset held low while the sensor toggles: outputs stay quiet
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.prize_sensor = ~bus.prize_sensor;
      tick();
      check("rst_inc",  int'(bus.increment_score), 0);
      check("rst_pend", int'(bus.pending), 0);
      check("rst_ovf",  int'(bus.overflow), 0);
      check("rst_busy", int'(bus.busy), 0);
    end

`ifndef SENDER_DEBOUNCE_EN
    // Single hit: 4-edge latency to pending, 4-cycle pulse, busy clears 4 cycles after the fall
    tbl[0]  = '{1'b1, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 0, 0, 0, 0};
    tbl[3]  = '{1'b1, 0, 1, 0, 1};
    tbl[4]  = '{1'b1, 1, 0, 0, 1};
    tbl[5]  = '{1'b1, 1, 0, 0, 1};
    tbl[6]  = '{1'b0, 1, 0, 0, 1};
    tbl[7]  = '{1'b0, 1, 0, 0, 1};
    tbl[8]  = '{1'b0, 0, 0, 0, 1};
    tbl[9]  = '{1'b0, 0, 0, 0, 1};
    tbl[10] = '{1'b0, 0, 0, 0, 1};
    tbl[11] = '{1'b0, 0, 0, 0, 1};
    tbl[12] = '{1'b0, 0, 0, 0, 0};
    tbl[13] = '{1'b0, 0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      bus.prize_sensor = tbl[i].sensor;
      bus.game_active  = 1'b1;
      tick();
      check($sformatf("single_inc[%0d]", i + 1),  int'(bus.increment_score), tbl[i].inc);
      check($sformatf("single_pend[%0d]", i + 1), int'(bus.pending), tbl[i].pend);
      check($sformatf("single_ovf[%0d]", i + 1),  int'(bus.overflow), tbl[i].ovf);
      check($sformatf("single_busy[%0d]", i + 1), int'(bus.busy), tbl[i].busy);
    end

    // Five hits on alternate cycles: queue saturates at 3, fifth hit overflows
    do_reset();
    clear_stim();
    for (int n = 1; n <= 10; n++) sens_v[n] = n[0];
    run(45);
    find_rises(45);
    check("burst_pend_e4",   pend_h[4], 1);
    check("burst_pend_e10",  pend_h[10], 3);
    check("burst_ovf_e11",   ovf_h[11], 0);
    check("burst_ovf_e12",   ovf_h[12], 1);
    check("burst_pend_e12",  pend_h[12], 3);
    check("burst_rises",     n_rises, 4);
    check("burst_first",     rises[0], 5);
    check("burst_period1",   rises[1] - rises[0], 9);
    check("burst_period3",   rises[3] - rises[2], 9);
    check("burst_last",      rises[3], 32);
    check("burst_width_hi",  inc_h[8], 1);
    check("burst_width_lo",  inc_h[9], 0);
    check("burst_pend_e32",  pend_h[32], 0);
    check("burst_busy_e39",  busy_h[39], 1);
    check("burst_busy_e40",  busy_h[40], 0);
    check("burst_ovf_stick", ovf_h[45], 1);

    // game_active dropped during the second of three queued pulses
    do_reset();
    clear_stim();
    for (int n = 1; n <= 5; n++) sens_v[n] = n[0];
    for (int n = 20; n <= 29; n++) sens_v[n] = ~n[0];
    for (int n = 14; n < NS; n++) act_v[n] = 1'b0;
    run(40);
    find_rises(40);
    check("drop_pend_e8",   pend_h[8], 2);
    check("drop_rises",     n_rises, 2);
    check("drop_second",    rises[1], 14);
    check("drop_inc_e15",   inc_h[15], 1);
    check("drop_inc_e16",   inc_h[16], 0);
    check("drop_pend_e15",  pend_h[15], 1);
    check("drop_pend_e16",  pend_h[16], 0);
    max_pend(16, 40, m);
    check("drop_pend_max",  m, 0);
    check("drop_busy_e19",  busy_h[19], 1);
    check("drop_busy_e20",  busy_h[20], 0);
    check("drop_ovf",       ovf_h[40], 0);

    // Hit lands on the launch edge with one entry queued
    do_reset();
    clear_stim();
    sens_v[1]  = 1'b1;
    sens_v[7]  = 1'b1;
    sens_v[11] = 1'b1;
    run(30);
    find_rises(30);
    check("coll_pend_e10", pend_h[10], 1);
    check("coll_pend_e13", pend_h[13], 1);
    check("coll_inc_e13",  inc_h[13], 0);
    check("coll_inc_e14",  inc_h[14], 1);
    check("coll_pend_e14", pend_h[14], 1);
    check("coll_rises",    n_rises, 3);
    check("coll_third",    rises[2], 23);
    check("coll_pend_e23", pend_h[23], 0);
    check("coll_ovf",      ovf_h[30], 0);

    // Reset asserted mid-pulse with a hit still queued
    do_reset();
    clear_stim();
    sens_v[1] = 1'b1;
    sens_v[3] = 1'b1;
    run(6);
    check("mid_inc_before",  inc_h[6], 1);
    check("mid_pend_before", pend_h[6], 1);
    reset = 1'b0;
    bus.prize_sensor = 1'b0;
    tick();
    check("mid_inc_reset",  int'(bus.increment_score), 0);
    check("mid_pend_reset", int'(bus.pending), 0);
    check("mid_busy_reset", int'(bus.busy), 0);
    reset = 1'b1;
    clear_stim();
    run(20);
    find_rises(20);
    check("mid_no_pulse", n_rises, 0);
`else
    // A 3-cycle glitch is rejected by the debouncer
    do_reset();
    clear_stim();
    for (int n = 1; n <= 3; n++) sens_v[n] = 1'b1;
    run(25);
    find_rises(25);
    max_pend(0, 25, m);
    check("glitch_pend_max", m, 0);
    check("glitch_rises",    n_rises, 0);
    check("glitch_busy",     busy_h[25], 0);

    // A 10-cycle high is one hit, counted 11 edges after the sensor rise
    do_reset();
    clear_stim();
    for (int n = 1; n <= 10; n++) sens_v[n] = 1'b1;
    run(30);
    find_rises(30);
    check("deb_pend_e10", pend_h[10], 0);
    check("deb_pend_e11", pend_h[11], 1);
    check("deb_rises",    n_rises, 1);
    check("deb_rise_at",  rises[0], 12);
    check("deb_pend_e12", pend_h[12], 0);
    check("deb_ovf",      ovf_h[30], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
